bdf_sched_seq: RTL and testbench

BDF_SCHED_SEQ -- requirements
Module: bdf_sched_seq

---
 rtl/bdf_sched_seq.sv | 155 +++++++++++++++
 tb/tb_bdf_sched_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bdf_sched_seq.sv
`default_nettype none
// ============================================================================
// Module   : bdf_sched_seq
// Brief    : Static BDF schedule sequencer. It replays a stored code program of
//            push/pop commands across buffers for N iterations, and stalls
//            each step until every addressed buffer is ready.
//            Optional stall counter: define BDF_SEQ_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bdf_sched_seq #(
  parameter  int NUM_BUFFERS = 12,
  parameter  int CODE_LENGTH = 64,
  parameter  int ITER_WIDTH  = 16,
  localparam int CODE_WIDTH  = 2 * NUM_BUFFERS,
  localparam int AW          = $clog2(CODE_LENGTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   prog_we,
  input  logic [AW-1:0]          prog_addr,
  input  logic [CODE_WIDTH-1:0]  prog_wdata,
  input  logic [AW:0]            prog_len,
  input  logic [ITER_WIDTH-1:0]  iterations,
  input  logic                   start,
  input  logic [NUM_BUFFERS-1:0] buf_ready,
  output logic [NUM_BUFFERS-1:0] buf_push,
  output logic [NUM_BUFFERS-1:0] buf_pop,
  output logic                   busy,
  output logic                   done,
  output logic [AW-1:0]          pc,
  output logic [ITER_WIDTH-1:0]  iter_cnt
`ifdef BDF_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]            stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [AW:0] LEN_MAX = (AW + 1)'(CODE_LENGTH);

  state_t                   state_q;
  state_t                   state_d;
  logic [CODE_WIDTH-1:0]    code_mem [CODE_LENGTH];
  logic [CODE_WIDTH-1:0]    code_word;
  logic [NUM_BUFFERS-1:0]   push_fld;
  logic [NUM_BUFFERS-1:0]   pop_fld;
  logic [NUM_BUFFERS-1:0]   need;
  logic                     fire;
  logic                     accept;
  logic                     last_step;
  logic                     last_iter;
  logic [AW:0]              len_clamped;
  logic [AW:0]              len_q;
  logic [ITER_WIDTH-1:0]    iters_q;

  // Code store is deliberately unreset so a program survives a reset.
  always_ff @(posedge clk) begin
    if (prog_we && (state_q == S_IDLE)) begin
      code_mem[prog_addr] <= prog_wdata;
    end
  end

  assign code_word = code_mem[pc];

  for (genvar i = 0; i < NUM_BUFFERS; i++) begin : g_buf
    assign push_fld[i] = code_word[2*i];
    assign pop_fld[i]  = code_word[2*i+1];
    assign need[i]     = code_word[2*i] | code_word[2*i+1];
  end

  // An all-zero word needs no buffer, so it always fires.
  assign fire        = &(~need | buf_ready);
  assign accept      = (state_q == S_IDLE) && start;
  assign len_clamped = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
  assign last_step   = ({1'b0, pc} == (len_q - (AW + 1)'(1)));
  assign last_iter   = (iter_cnt == (iters_q - ITER_WIDTH'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    done     = 1'b0;
    buf_push = '0;
    buf_pop  = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = ((len_clamped == '0) || (iterations == '0)) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (fire) begin
          buf_push = push_fld;
          buf_pop  = pop_fld;
          if (last_step && last_iter) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= '0;
      iter_cnt <= '0;
      len_q    <= '0;
      iters_q  <= '0;
    end else if (accept) begin
      pc       <= '0;
      iter_cnt <= '0;
      len_q    <= len_clamped;
      iters_q  <= iterations;
    end else if ((state_q == S_RUN) && fire) begin
      if (last_step) begin
        pc       <= '0;
        iter_cnt <= iter_cnt + ITER_WIDTH'(1);
      end else begin
        pc <= pc + AW'(1);
      end
    end
  end

`ifdef BDF_SEQ_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (accept) begin
      stall_cnt <= '0;
    end else if ((state_q == S_RUN) && !fire && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bdf_sched_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bdf_sched_seq
// Brief    : Bench for bdf_sched_seq (4 buffers, 8-word store); the reference
//            tracks a flat step count k, with pc = k % len and iter = k / len.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bdf_sched_seq;

  localparam int NB = 4;
  localparam int CL = 8;
  localparam int IW = 16;
  localparam int AW = 3;
  localparam int CW = 2 * NB;

  logic          clk = 1'b0;
  logic          reset;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [CW-1:0] prog_wdata;
  logic [AW:0]   prog_len;
  logic [IW-1:0] iterations;
  logic          start;
  logic [NB-1:0] buf_ready;
  logic [NB-1:0] buf_push;
  logic [NB-1:0] buf_pop;
  logic          busy;
  logic          done;
  logic [AW-1:0] pc;
  logic [IW-1:0] iter_cnt;
`ifdef BDF_SEQ_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  int            total = 0;
  int            bad   = 0;
  logic [CW-1:0] mem_m [CL];

  always #5 clk = ~clk;

  bdf_sched_seq #(
    .NUM_BUFFERS (NB),
    .CODE_LENGTH (CL),
    .ITER_WIDTH  (IW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .prog_len   (prog_len),
    .iterations (iterations),
    .start      (start),
    .buf_ready  (buf_ready),
    .buf_push   (buf_push),
    .buf_pop    (buf_pop),
    .busy       (busy),
    .done       (done),
    .pc         (pc),
    .iter_cnt   (iter_cnt)
`ifdef BDF_SEQ_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic write_word(input int a, input logic [CW-1:0] d);
    prog_we    = 1'b1;
    prog_addr  = AW'(a);
    prog_wdata = d;
    tick();
    prog_we    = 1'b0;
    mem_m[a]   = d;
  endtask

  // mode: 0 all ready, 1 random ready, 2 buffer 0 not ready for first 4 cycles.
  // abort_k >= 0 asserts reset when step k is reached; inject pokes prog_we/start mid-run.
  task automatic do_run(input int len_in, input int iters, input int mode,
                        input int abort_k, input bit inject);
    int            elen, totk, k, cyc, stalls;
    logic [CW-1:0] w;
    logic [NB-1:0] need, ep, eo;
    bit            fire;
    elen = (len_in > CL) ? CL : len_in;
    totk = elen * iters;
    start      = 1'b1;
    prog_len   = (AW + 1)'(len_in);
    iterations = IW'(iters);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    tick();
    start  = 1'b0;
    k      = 0;
    cyc    = 0;
    stalls = 0;
    while (k < totk && cyc < 400) begin
      case (mode)
        0:       buf_ready = '1;
        1:       buf_ready = NB'($urandom | $urandom);
        default: buf_ready = (cyc < 4) ? ~NB'(1) : '1;
      endcase
      if (inject && cyc == 1) begin
        prog_we    = 1'b1;
        prog_addr  = '0;
        prog_wdata = ~mem_m[0];
        start      = 1'b1;
        prog_len   = (AW + 1)'(1);
        iterations = IW'(1);
      end
      #1;
      w = mem_m[k % elen];
      for (int i = 0; i < NB; i++) begin
        need[i] = (w[2*i+:2] != 2'b00);
        ep[i]   = w[2*i];
        eo[i]   = w[2*i+1];
      end
      fire = ((need & ~buf_ready) == '0);
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      chk("run_pc", pc, k % elen);
      chk("run_iter", iter_cnt, k / elen);
      chk("run_push", buf_push, fire ? ep : '0);
      chk("run_pop", buf_pop, fire ? eo : '0);
      if (abort_k >= 0 && k == abort_k) begin
        reset = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_push", buf_push, 0);
        chk("rst_pop", buf_pop, 0);
        chk("rst_pc", pc, 0);
        chk("rst_iter", iter_cnt, 0);
        tick();
        reset   = 1'b0;
        prog_we = 1'b0;
        start   = 1'b0;
        tick();
        return;
      end
      if (fire) k++;
      else      stalls++;
      tick();
      cyc++;
      if (inject && cyc == 2) begin
        prog_we = 1'b0;
        start   = 1'b0;
      end
    end
    if (k < totk) begin
      total++;
      bad++;
      $error("FAIL run_timeout observed=%0d expected=%0d", k, totk);
    end
    // DONE cycle; a start here must be ignored.
    buf_ready  = NB'($urandom);
    start      = 1'b1;
    prog_len   = (AW + 1)'(1);
    iterations = IW'(1);
    #1;
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_push", buf_push, 0);
    chk("done_pop", buf_pop, 0);
    chk("done_pc", pc, 0);
    chk("done_iter", iter_cnt, (totk == 0) ? 0 : iters);
`ifdef BDF_SEQ_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, stalls);
    if (mode == 2) chk("stall_cnt4", stall_cnt, 4);
`endif
    tick();
    start = 1'b0;
    #1;
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_push", buf_push, 0);
    chk("post_pc", pc, 0);
    chk("post_iter", iter_cnt, (totk == 0) ? 0 : iters);
  endtask

  initial begin
    logic [CW-1:0] rw;
    int            rl, ri;
    reset      = 1'b1;
    prog_we    = 1'b0;
    prog_addr  = '0;
    prog_wdata = '0;
    prog_len   = '0;
    iterations = '0;
    start      = 1'b0;
    buf_ready  = '1;
    tick();
    tick();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_push", buf_push, 0);
    chk("reset_pop", buf_pop, 0);
    chk("reset_pc", pc, 0);
    chk("reset_iter", iter_cnt, 0);
`ifdef BDF_SEQ_STALL_CNT_EN
    chk("reset_stall", stall_cnt, 0);
`endif
    reset = 1'b0;
    tick();

    // push b0, pop b0, push b1 + pop b2
    write_word(0, CW'(8'b0000_0001));
    write_word(1, CW'(8'b0000_0010));
    write_word(2, CW'(8'b0010_0100));
    do_run(3, 2, 0, -1, 1'b0);
    do_run(3, 1, 2, -1, 1'b0);
    do_run(3, 0, 0, -1, 1'b0);
    do_run(0, 2, 0, -1, 1'b0);
    do_run(3, 2, 0, 5, 1'b0);
    do_run(3, 2, 0, -1, 1'b0);

    for (int a = 0; a < CL; a++) begin
      rw = CW'($urandom);
      if (a == 3) rw = '0;
      write_word(a, rw);
    end
    do_run(8, 2, 1, -1, 1'b1);
    do_run(8, 1, 0, -1, 1'b0);
    do_run(15, 2, 1, -1, 1'b0);

    for (int n = 0; n < 4; n++) begin
      for (int a = 0; a < CL; a++) begin
        rw = CW'($urandom);
        if ($urandom_range(0, 3) == 0) rw = '0;
        write_word(a, rw);
      end
      rl = $urandom_range(1, CL);
      ri = $urandom_range(1, 3);
      do_run(rl, ri, 1, -1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
